param_vending_machine: RTL and testbench
========================================

PARAM_VENDING_MACHINE -- requirements
Module: param_vending_machine

Parameters
REQ-001 NUM_ITEMS, default 4, number of selectable products (2..8).
REQ-002 PRICES, default {4'd3,4'd2,4'd2,4'd1}, packed 4-bit price per item, item 0 in LSBs, each 1..9 coins.
REQ-003 MAX_CREDIT, default 9, highest credit held (coins), <=9.
REQ-004 STOCK_INIT, default 3, per-item stock loaded at reset/restock, 1..15.

Interface
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 i_coin  in  1  one-coin insert, one-cycle pulse per coin.
REQ-008 i_sel  in  NUM_ITEMS  item request, one-hot, one-cycle pulse.
REQ-009 i_refund  in  1  cancel request, one-cycle pulse.
REQ-010 i_restock  in  1  reload all stock to STOCK_INIT.
REQ-011 o_led  out  NUM_ITEMS  bit k=1 when credit>=PRICES[k] and stock[k]>0, state CREDIT.
REQ-012 o_sold_out  out  NUM_ITEMS  bit k=1 when stock[k]==0.
REQ-013 o_vend  out  NUM_ITEMS  one-hot, one-cycle dispense pulse.
REQ-014 o_change  out  4  coins returned, valid only with o_change_valid.
REQ-015 o_change_valid  out  1  one-cycle change/refund pulse.
REQ-016 o_coin_reject  out  1  one-cycle pulse, coin not accepted.
REQ-017 o_credit  out  4  current credit, BCD digit 0..9, for segment decoder.

Function
REQ-018 FSM states IDLE, CREDIT, VEND, CHANGE; all outputs registered.
REQ-019 IDLE: accepted coin -> credit=1, next CREDIT; i_sel/i_refund ignored.
REQ-020 CREDIT: accepted coin -> credit+1; credit==MAX_CREDIT -> coin rejected, credit unchanged.
REQ-021 CREDIT: valid sel = exactly one bit set, credit>=PRICES[k], stock[k]>0 -> next VEND; otherwise sel ignored, stay CREDIT.
REQ-022 VEND (one cycle): o_vend[k]=1, stock[k]-1, credit-=PRICES[k]; next CHANGE if remainder>0 else IDLE.
REQ-023 CHANGE (one cycle): o_change=credit, o_change_valid=1, credit=0, next IDLE.
REQ-024 CREDIT + i_refund -> next CHANGE returning full credit; refund beats same-cycle sel and coin.
REQ-025 CREDIT, valid sel + coin same cycle: sel wins, coin rejected.
REQ-026 Coin during VEND or CHANGE rejected (o_coin_reject pulse, no credit change).
REQ-027 Latency: o_vend one cycle after sel sampled; o_change_valid one cycle after o_vend, or one cycle after refund sampled.
REQ-028 i_restock honoured only in IDLE; ignored otherwise; coin in same IDLE cycle still accepted.
REQ-029 Stock never wraps below 0; credit never exceeds MAX_CREDIT nor underflows.
REQ-030 o_credit tracks credit register, same cycle as update.

Reset
REQ-031 rst (sync, high) at any state: state=IDLE, credit=0, stock[*]=STOCK_INIT, o_vend=0, o_change=0, o_change_valid=0, o_coin_reject=0, o_led=0, o_sold_out=0, o_credit=0.
REQ-032 Reset mid-VEND/CHANGE aborts: no vend/change pulse, credit lost.
REQ-033 All inputs ignored in the cycle rst is high.

Verification
REQ-034 Defaults; coin x1, i_sel=0001 -> o_vend=0001 one cycle, no change pulse, IDLE, o_credit=0, stock[0]=2.
REQ-035 Coin x3, i_sel=0010 -> o_vend=0010, next cycle o_change=1 with o_change_valid, o_credit 3->1->0.
REQ-036 Coin x1, i_sel=1000 (price 3) -> no vend, o_led=0001, credit stays 1; i_refund -> o_change=1.
REQ-037 Coin x10 -> 10th coin o_coin_reject=1, o_credit=9; i_sel=0101 (two bits) ignored.
REQ-038 Buy item 0 three times -> o_sold_out=0001, 4th attempt no vend; i_restock in IDLE -> o_sold_out=0000.
REQ-039 Coin x2, i_sel=0010 with rst in VEND cycle -> no o_vend, no change, o_credit=0, IDLE.

Source files
------------

// File: rtl/param_vending_machine.sv
// Parameterised coin-operated vending controller: one-coin credit, one-hot item
// selection, per-item stock tracking, change/refund pulses. All outputs registered.
module param_vending_machine #(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter logic [4*NUM_ITEMS-1:0] PRICES = {4'd3, 4'd2, 4'd2, 4'd1},
  parameter int unsigned MAX_CREDIT = 9,
  parameter int unsigned STOCK_INIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_coin,
  input  logic [NUM_ITEMS-1:0] i_sel,
  input  logic                 i_refund,
  input  logic                 i_restock,
  output logic [NUM_ITEMS-1:0] o_led,
  output logic [NUM_ITEMS-1:0] o_sold_out,
  output logic [NUM_ITEMS-1:0] o_vend,
  output logic [3:0]           o_change,
  output logic                 o_change_valid,
  output logic                 o_coin_reject,
  output logic [3:0]           o_credit
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_CR   = CNT_W'(MAX_CREDIT);
  localparam logic [CNT_W-1:0] STOCK_LD = CNT_W'(STOCK_INIT);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_e;

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   credit_q, credit_d;
  logic [NUM_ITEMS-1:0][CNT_W-1:0]    stock_q, stock_d;
  logic [NUM_ITEMS-1:0]               vend_sel_q, vend_sel_d;
  logic [NUM_ITEMS-1:0]               vend_q, vend_d;
  logic [CNT_W-1:0]                   change_q, change_d;
  logic                               change_valid_q, change_valid_d;
  logic                               coin_reject_q, coin_reject_d;
  logic [NUM_ITEMS-1:0]               led_q, led_d;
  logic [NUM_ITEMS-1:0]               sold_out_q, sold_out_d;

  logic                               sel_onehot_c;
  logic                               sel_valid_c;
  logic [CNT_W-1:0]                   sel_price_c;
  logic [CNT_W-1:0]                   sel_stock_c;
  logic [CNT_W-1:0]                   vend_price_c;

  // Price/stock of the requested item and price of the item being dispensed
  always_comb begin
    sel_onehot_c = (i_sel != '0) && ((i_sel & (i_sel - NUM_ITEMS'(1))) == '0);
    sel_price_c  = '0;
    sel_stock_c  = '0;
    vend_price_c = '0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      if (i_sel[k]) begin
        sel_price_c = PRICES[CNT_W*k +: CNT_W];
        sel_stock_c = stock_q[k];
      end
      if (vend_sel_q[k]) begin
        vend_price_c = PRICES[CNT_W*k +: CNT_W];
      end
    end
    sel_valid_c = sel_onehot_c && (credit_q >= sel_price_c) && (sel_stock_c != '0);
  end

  // Next state; each state's actions land on the edge that leaves it
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    stock_d        = stock_q;
    vend_sel_d     = vend_sel_q;
    vend_d         = '0;
    change_d       = '0;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_restock) begin
          for (int k = 0; k < NUM_ITEMS; k++) stock_d[k] = STOCK_LD;
        end
        if (i_coin) begin
          credit_d = CNT_W'(1);
          state_d  = CREDIT;
        end
      end
      CREDIT: begin
        if (i_refund) begin
          coin_reject_d = i_coin;
          state_d       = CHANGE;
        end else if (sel_valid_c) begin
          coin_reject_d = i_coin;
          vend_sel_d    = i_sel;
          state_d       = VEND;
        end else if (i_coin) begin
          if (credit_q >= MAX_CR) coin_reject_d = 1'b1;
          else                    credit_d      = credit_q + CNT_W'(1);
        end
      end
      VEND: begin
        coin_reject_d = i_coin;
        vend_d        = vend_sel_q;
        for (int k = 0; k < NUM_ITEMS; k++) begin
          if (vend_sel_q[k] && (stock_q[k] != '0)) stock_d[k] = stock_q[k] - CNT_W'(1);
        end
        credit_d = (credit_q >= vend_price_c) ? credit_q - vend_price_c : '0;
        state_d  = (credit_d != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_reject_d  = i_coin;
        change_d       = credit_q;
        change_valid_d = 1'b1;
        credit_d       = '0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int k = 0; k < NUM_ITEMS; k++) begin
      sold_out_d[k] = (stock_d[k] == '0);
      led_d[k]      = (state_d == CREDIT) && (credit_d >= PRICES[CNT_W*k +: CNT_W])
                      && (stock_d[k] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      for (int k = 0; k < NUM_ITEMS; k++) stock_q[k] <= STOCK_LD;
      vend_sel_q     <= '0;
      vend_q         <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      led_q          <= '0;
      sold_out_q     <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      stock_q        <= stock_d;
      vend_sel_q     <= vend_sel_d;
      vend_q         <= vend_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      led_q          <= led_d;
      sold_out_q     <= sold_out_d;
    end
  end

  assign o_led          = led_q;
  assign o_sold_out     = sold_out_q;
  assign o_vend         = vend_q;
  assign o_change       = change_q;
  assign o_change_valid = change_valid_q;
  assign o_coin_reject  = coin_reject_q;
  assign o_credit       = credit_q;

endmodule

// File: tb/tb_param_vending_machine.sv
// Directed bench for param_vending_machine with default parameters (prices 1,2,2,3; stock 3).
module tb_param_vending_machine;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_coin;
  logic [3:0] i_sel;
  logic       i_refund;
  logic       i_restock;
  logic [3:0] o_led;
  logic [3:0] o_sold_out;
  logic [3:0] o_vend;
  logic [3:0] o_change;
  logic       o_change_valid;
  logic       o_coin_reject;
  logic [3:0] o_credit;

  int checks = 0;
  int errors = 0;

  param_vending_machine dut (
    .clk(clk), .rst(rst), .i_coin(i_coin), .i_sel(i_sel), .i_refund(i_refund),
    .i_restock(i_restock), .o_led(o_led), .o_sold_out(o_sold_out), .o_vend(o_vend),
    .o_change(o_change), .o_change_valid(o_change_valid), .o_coin_reject(o_coin_reject),
    .o_credit(o_credit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; i_coin = 1'b0; i_sel = '0; i_refund = 1'b0; i_restock = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic insert_coins(input int n);
    for (int i = 0; i < n; i++) begin
      i_coin = 1'b1; tick();
    end
    i_coin = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_coin = 1'b1; i_sel = 4'b0001; i_refund = 1'b0; i_restock = 1'b0;
    tick(); tick();
    rst = 1'b0; i_coin = 1'b0; i_sel = '0;
    checks++; if (o_credit !== 4'd0) begin errors++; $display("FAIL reset_credit: got %0d expected 0", o_credit); end
    checks++; if (o_led !== 4'b0000) begin errors++; $display("FAIL reset_led: got %b expected 0000", o_led); end
    checks++; if (o_sold_out !== 4'b0000) begin errors++; $display("FAIL reset_sold_out: got %b expected 0000", o_sold_out); end
    checks++; if ({o_vend, o_change, o_change_valid, o_coin_reject} !== 10'd0) begin
      errors++; $display("FAIL reset_pulses: got vend=%b change=%0d cv=%b rej=%b expected all 0",
                         o_vend, o_change, o_change_valid, o_coin_reject);
    end
  endtask

  task automatic test_exact_vend();
    apply_reset();
    insert_coins(1);
    checks++; if (o_credit !== 4'd1) begin errors++; $display("FAIL exact_credit: got %0d expected 1", o_credit); end
    checks++; if (o_led !== 4'b0001) begin errors++; $display("FAIL exact_led: got %b expected 0001", o_led); end
    i_sel = 4'b0001; tick(); i_sel = '0;
    checks++; if (o_vend !== 4'b0000) begin errors++; $display("FAIL exact_vend_early: got %b expected 0000", o_vend); end
    tick();
    checks++; if (o_vend !== 4'b0001) begin errors++; $display("FAIL exact_vend: got %b expected 0001", o_vend); end
    checks++; if (o_credit !== 4'd0) begin errors++; $display("FAIL exact_credit_after: got %0d expected 0", o_credit); end
    tick();
    checks++; if (o_vend !== 4'b0000 || o_change_valid !== 1'b0) begin
      errors++; $display("FAIL exact_no_change: got vend=%b cv=%b expected 0000/0", o_vend, o_change_valid);
    end
    // Back in IDLE: sel and refund must be ignored
    i_sel = 4'b0001; i_refund = 1'b1; tick(); i_sel = '0; i_refund = 1'b0; tick();
    checks++; if (o_vend !== 4'b0000 || o_change_valid !== 1'b0 || o_credit !== 4'd0) begin
      errors++; $display("FAIL idle_ignore: got vend=%b cv=%b credit=%0d expected 0000/0/0",
                         o_vend, o_change_valid, o_credit);
    end
  endtask

  task automatic test_change();
    apply_reset();
    insert_coins(3);
    checks++; if (o_led !== 4'b1111) begin errors++; $display("FAIL change_led: got %b expected 1111", o_led); end
    i_sel = 4'b0010; tick(); i_sel = '0;
    checks++; if (o_credit !== 4'd3) begin errors++; $display("FAIL change_credit_vend: got %0d expected 3", o_credit); end
    tick();
    checks++; if (o_vend !== 4'b0010 || o_credit !== 4'd1 || o_change_valid !== 1'b0) begin
      errors++; $display("FAIL change_vend: got vend=%b credit=%0d cv=%b expected 0010/1/0",
                         o_vend, o_credit, o_change_valid);
    end
    tick();
    checks++; if (o_change_valid !== 1'b1 || o_change !== 4'd1 || o_credit !== 4'd0 || o_vend !== 4'b0000) begin
      errors++; $display("FAIL change_pulse: got cv=%b change=%0d credit=%0d vend=%b expected 1/1/0/0000",
                         o_change_valid, o_change, o_credit, o_vend);
    end
    tick();
    checks++; if (o_change_valid !== 1'b0) begin errors++; $display("FAIL change_one_cycle: got %b expected 0", o_change_valid); end
  endtask

  task automatic test_refund();
    apply_reset();
    insert_coins(1);
    i_sel = 4'b1000; tick(); i_sel = '0; tick();
    checks++; if (o_vend !== 4'b0000 || o_credit !== 4'd1 || o_led !== 4'b0001) begin
      errors++; $display("FAIL refund_short: got vend=%b credit=%0d led=%b expected 0000/1/0001",
                         o_vend, o_credit, o_led);
    end
    i_refund = 1'b1; tick(); i_refund = 1'b0;
    checks++; if (o_change_valid !== 1'b0) begin errors++; $display("FAIL refund_early: got %b expected 0", o_change_valid); end
    tick();
    checks++; if (o_change_valid !== 1'b1 || o_change !== 4'd1 || o_credit !== 4'd0) begin
      errors++; $display("FAIL refund_pulse: got cv=%b change=%0d credit=%0d expected 1/1/0",
                         o_change_valid, o_change, o_credit);
    end
  endtask

  task automatic test_max_credit();
    apply_reset();
    insert_coins(9);
    checks++; if (o_credit !== 4'd9 || o_coin_reject !== 1'b0) begin
      errors++; $display("FAIL max_nine: got credit=%0d rej=%b expected 9/0", o_credit, o_coin_reject);
    end
    insert_coins(1);
    checks++; if (o_credit !== 4'd9 || o_coin_reject !== 1'b1) begin
      errors++; $display("FAIL max_reject: got credit=%0d rej=%b expected 9/1", o_credit, o_coin_reject);
    end
    i_sel = 4'b0101; tick(); i_sel = '0; tick();
    checks++; if (o_vend !== 4'b0000 || o_credit !== 4'd9 || o_led !== 4'b1111) begin
      errors++; $display("FAIL max_two_hot: got vend=%b credit=%0d led=%b expected 0000/9/1111",
                         o_vend, o_credit, o_led);
    end
    i_refund = 1'b1; tick(); i_refund = 1'b0; tick();
    checks++; if (o_change_valid !== 1'b1 || o_change !== 4'd9) begin
      errors++; $display("FAIL max_refund: got cv=%b change=%0d expected 1/9", o_change_valid, o_change);
    end
  endtask

  task automatic test_sold_out();
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      insert_coins(1);
      i_sel = 4'b0001; tick(); i_sel = '0; tick();
      checks++; if (o_vend !== 4'b0001) begin errors++; $display("FAIL sold_buy%0d: got %b expected 0001", n, o_vend); end
    end
    tick();
    checks++; if (o_sold_out !== 4'b0001) begin errors++; $display("FAIL sold_flag: got %b expected 0001", o_sold_out); end
    insert_coins(1);
    checks++; if (o_led !== 4'b0000) begin errors++; $display("FAIL sold_led: got %b expected 0000", o_led); end
    i_sel = 4'b0001; tick(); i_sel = '0; tick();
    checks++; if (o_vend !== 4'b0000 || o_credit !== 4'd1) begin
      errors++; $display("FAIL sold_no_vend: got vend=%b credit=%0d expected 0000/1", o_vend, o_credit);
    end
    i_restock = 1'b1; tick(); i_restock = 1'b0;
    checks++; if (o_sold_out !== 4'b0001) begin errors++; $display("FAIL restock_in_credit: got %b expected 0001", o_sold_out); end
    i_refund = 1'b1; tick(); i_refund = 1'b0; tick();
    i_restock = 1'b1; tick(); i_restock = 1'b0;
    checks++; if (o_sold_out !== 4'b0000) begin errors++; $display("FAIL restock_idle: got %b expected 0000", o_sold_out); end
  endtask

  task automatic test_reset_mid_vend();
    apply_reset();
    insert_coins(2);
    i_sel = 4'b0010; tick(); i_sel = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (o_vend !== 4'b0000 || o_credit !== 4'd0 || o_change_valid !== 1'b0) begin
      errors++; $display("FAIL rstvend_abort: got vend=%b credit=%0d cv=%b expected 0000/0/0",
                         o_vend, o_credit, o_change_valid);
    end
    tick();
    checks++; if (o_vend !== 4'b0000 || o_change_valid !== 1'b0) begin
      errors++; $display("FAIL rstvend_later: got vend=%b cv=%b expected 0000/0", o_vend, o_change_valid);
    end
    insert_coins(1);
    checks++; if (o_credit !== 4'd1 || o_coin_reject !== 1'b0) begin
      errors++; $display("FAIL rstvend_idle: got credit=%0d rej=%b expected 1/0", o_credit, o_coin_reject);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    insert_coins(2);
    i_sel = 4'b0001; i_coin = 1'b1; tick(); i_sel = '0;
    checks++; if (o_coin_reject !== 1'b1 || o_credit !== 4'd2) begin
      errors++; $display("FAIL b2b_sel_wins: got rej=%b credit=%0d expected 1/2", o_coin_reject, o_credit);
    end
    tick();
    checks++; if (o_vend !== 4'b0001 || o_coin_reject !== 1'b1 || o_credit !== 4'd1) begin
      errors++; $display("FAIL b2b_vend_coin: got vend=%b rej=%b credit=%0d expected 0001/1/1",
                         o_vend, o_coin_reject, o_credit);
    end
    tick(); i_coin = 1'b0;
    checks++; if (o_change_valid !== 1'b1 || o_change !== 4'd1 || o_coin_reject !== 1'b1 || o_credit !== 4'd0) begin
      errors++; $display("FAIL b2b_change_coin: got cv=%b change=%0d rej=%b credit=%0d expected 1/1/1/0",
                         o_change_valid, o_change, o_coin_reject, o_credit);
    end
    insert_coins(2);
    i_refund = 1'b1; i_sel = 4'b0001; i_coin = 1'b1; tick();
    i_refund = 1'b0; i_sel = '0; i_coin = 1'b0;
    checks++; if (o_coin_reject !== 1'b1 || o_credit !== 4'd2) begin
      errors++; $display("FAIL b2b_refund_coin: got rej=%b credit=%0d expected 1/2", o_coin_reject, o_credit);
    end
    tick();
    checks++; if (o_change_valid !== 1'b1 || o_change !== 4'd2 || o_vend !== 4'b0000) begin
      errors++; $display("FAIL b2b_refund_wins: got cv=%b change=%0d vend=%b expected 1/2/0000",
                         o_change_valid, o_change, o_vend);
    end
  endtask

  initial begin
    test_reset();
    test_exact_vend();
    test_change();
    test_refund();
    test_max_credit();
    test_sold_out();
    test_reset_mid_vend();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
